fetch_stage: RTL and testbench

Instruction fetch stage of the single-issue RV32I core. It holds the program counter and issues word reads to instruction memory over a request/response handshake. Returned instructions are captured in an IF/ID output register that feeds the decode/control stage. It also accepts PC redirects from branch, jal and jalr resolution and flushes wrong-path work.

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/if_id_reg.sv | 57 +++++
 rtl/fetch_stage.sv | 102 ++++++++++
 tb/tb_fetch_stage.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcode map, NOP encoding, fetch FSM state type.
// Pure declarations; no timing or flow-control behaviour of its own.
package riscv_pkg;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_L    = 7'b0000011;
  localparam logic [6:0] OPC_S    = 7'b0100011;
  localparam logic [6:0] OPC_B    = 7'b1100011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load captures a fetched word, flush beats load, consume empties.
// One-cycle register; holding (no consume) keeps contents stable for decode.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic        consume_i,
  input  logic        flush_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [6:0]  opcode_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end else if (consume_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= 32'h0000_0000;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign opcode_o   = instr_q[6:0];
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_q + 32'd4;

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch: PC + single-outstanding imem request FSM feeding the IF/ID register.
// gnt at t, rvalid at t+k -> id_valid at t+k+1; no new request while IF/ID is full and not consumed.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [6:0]  id_opcode,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  input  logic        id_ready
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         fire;
  logic         load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:   if (fire)        state_d = WAIT;
      WAIT:    if (imem_rvalid) state_d = FETCH;
      DRAIN:   if (imem_rvalid) state_d = FETCH;
      default:                  state_d = FETCH;
    endcase
    // A response arriving with the redirect retires the old request, so only a
    // request still in flight after this edge needs draining.
    if (redirect_valid) begin
      if (fire || ((state_q != FETCH) && !imem_rvalid)) begin
        state_d = DRAIN;
      end else begin
        state_d = FETCH;
      end
    end
  end

  always_comb begin
    imem_req  = rst_n && (state_q == FETCH) && (!id_valid || id_ready);
    imem_addr = pc_q;
    fire      = imem_req && imem_gnt;
    load      = (state_q == WAIT) && imem_rvalid && !redirect_valid;
  end

  always_comb begin
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    if (fire) begin
      pc_d       = pc_q + 32'd4;
      fetch_pc_d = pc_q;
    end
    if (redirect_valid) begin
      pc_d = word_align(redirect_pc);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      fetch_pc_q <= RESET_PC;
    end else begin
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (load),
    .instr_i    (imem_rdata),
    .pc_i       (fetch_pc_q),
    .consume_i  (id_valid && id_ready),
    .flush_i    (redirect_valid),
    .valid_o    (id_valid),
    .instr_o    (id_instr),
    .opcode_o   (id_opcode),
    .pc_o       (id_pc),
    .pc_plus4_o (id_pc_plus4)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage with a transaction-level reference model and a mock imem.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [6:0]  id_opcode;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        id_ready;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_opcode      (id_opcode),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .id_ready       (id_ready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
  endfunction

  // Reference model: one in-flight request flag plus a "response is stale" flag.
  bit          m_out, m_drop, m_v;
  logic [31:0] m_pc, m_fpc, m_instr, m_ipc;

  // Mock instruction memory.
  bit          mem_pend;
  logic [31:0] mem_addr;
  int          mem_wait;

  int p_gnt, p_rdy, p_redir, max_dly;

  task automatic model_reset();
    m_out = 0; m_drop = 0; m_v = 0;
    m_pc = 32'h0; m_fpc = 32'h0; m_instr = 32'h0000_0013; m_ipc = 32'h0;
    mem_pend = 0; mem_wait = 0;
  endtask

  task automatic run_cycle(input bit force_redir, input logic [31:0] force_pc);
    bit exp_req, fire, resp, deliver, n_out, n_drop;
    @(negedge clk);
    id_ready       = ($urandom_range(99) < p_rdy);
    redirect_valid = ($urandom_range(99) < p_redir);
    case ($urandom_range(3))
      0:       redirect_pc = 32'h0000_0103;
      1:       redirect_pc = 32'hFFFF_FFFE;
      default: redirect_pc = $urandom;
    endcase
    if (force_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = force_pc;
    end
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (mem_pend) begin
      if (mem_wait == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_addr);
        mem_pend    = 0;
      end else begin
        mem_wait--;
      end
    end
    #1;
    exp_req = !m_out && (!m_v || id_ready);
    check("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) check("imem_addr", imem_addr, m_pc);
    imem_gnt = imem_req && ($urandom_range(99) < p_gnt);
    if (imem_req && imem_gnt) begin
      mem_pend = 1;
      mem_addr = imem_addr;
      mem_wait = int'($urandom_range(max_dly));
    end

    fire    = exp_req && imem_gnt;
    resp    = m_out && imem_rvalid;
    deliver = resp && !m_drop && !redirect_valid;
    n_out   = fire ? 1'b1 : (resp ? 1'b0 : m_out);
    n_drop  = fire ? redirect_valid : (resp ? 1'b0 : (m_drop | (redirect_valid & m_out)));
    if (redirect_valid)      m_v = 0;
    else if (deliver)        m_v = 1;
    else if (m_v && id_ready) m_v = 0;
    if (deliver) begin
      m_instr = mem_word(m_fpc);
      m_ipc   = m_fpc;
    end
    if (fire) begin
      m_fpc = m_pc;
      m_pc  = m_pc + 32'd4;
    end
    if (redirect_valid) m_pc = {redirect_pc[31:2], 2'b00};
    m_out  = n_out;
    m_drop = n_drop;

    @(posedge clk);
    #1;
    check("id_valid", 32'(id_valid), 32'(m_v));
    check("id_instr", id_instr, m_instr);
    check("id_opcode", 32'(id_opcode), 32'(m_instr[6:0]));
    check("id_pc", id_pc, m_ipc);
    check("id_pc_plus4", id_pc_plus4, m_ipc + 32'd4);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 32'(imem_req), 32'h0);
    check({tag, "_id_valid"}, 32'(id_valid), 32'h0);
    check({tag, "_id_instr"}, id_instr, 32'h0000_0013);
    check({tag, "_id_opcode"}, 32'(id_opcode), 32'h13);
    check({tag, "_id_pc"}, id_pc, 32'h0);
    check({tag, "_id_pc_plus4"}, id_pc_plus4, 32'h4);
  endtask

  task automatic wait_outstanding(input string tag);
    int guard = 0;
    while (!m_out && guard < 200) begin
      run_cycle(0, 32'h0);
      guard++;
    end
    check({tag, "_reached_wait"}, 32'(m_out), 32'h1);
  endtask

  initial begin
    rst_n = 1'b0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    redirect_valid = 0; redirect_pc = 0; id_ready = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Ideal memory: back-to-back fetch at one instruction per two cycles.
    p_gnt = 100; p_rdy = 100; p_redir = 0; max_dly = 0;
    repeat (20) run_cycle(0, 32'h0);

    // Decode stalls with slow, bursty memory.
    p_gnt = 70; p_rdy = 40; p_redir = 0; max_dly = 3;
    repeat (150) run_cycle(0, 32'h0);

    // Redirect while a request is outstanding: target 0x103 aligns to 0x100.
    p_gnt = 100; p_rdy = 100; max_dly = 2;
    wait_outstanding("redir_wait");
    run_cycle(1, 32'h0000_0103);
    repeat (8) run_cycle(0, 32'h0);

    // Wrap of the PC at the top of the address space.
    p_gnt = 100; p_rdy = 100; max_dly = 0;
    repeat (3) run_cycle(0, 32'h0);
    run_cycle(1, 32'hFFFF_FFFC);
    repeat (8) run_cycle(0, 32'h0);

    // Fully randomized traffic including redirects.
    p_gnt = 60; p_rdy = 70; p_redir = 8; max_dly = 3;
    repeat (600) run_cycle(0, 32'h0);

    // Reset asserted with a request in flight.
    p_redir = 0; max_dly = 3;
    wait_outstanding("rst_wait");
    @(negedge clk);
    rst_n = 1'b0; imem_gnt = 0; imem_rvalid = 0; redirect_valid = 0;
    #1;
    check_reset_outputs("mid_rst");
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_hold_req", 32'(imem_req), 32'h0);
    end
    model_reset();
    rst_n = 1'b1;
    p_gnt = 80; p_rdy = 80; p_redir = 5;
    repeat (300) run_cycle(0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
